// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with configurable width, SCLK divider, mode, bit order
// and chip selects; transfers are requested through a valid/ready handshake.
//  state | meaning
//  IDLE  | cs_n high, sclk at idle level, ready for a request
//  LEAD  | cs_n asserted, one half-period before the first sclk edge
//  XFER  | 2*DATA_W sclk half-periods, shifting mosi and sampling miso
//  TRAIL | sclk back at idle, cs_n held for one half-period
//  GAP   | cs_n released, rx word published, minimum deselect time
module spi_master_cfg #(
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 10,
  parameter int NUM_CS    = 1,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CS_GAP    = 2,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] cs_n_o
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int HALF_W  = $clog2(2 * DATA_W);
  localparam int GAP_LEN = (CS_GAP < 1) ? 1 : CS_GAP;
  localparam int GAP_W   = $clog2(GAP_LEN + 1);

  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(2 * DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    XFER  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_ready_q, tx_ready_d;

  logic                accept;
  logic                start;
  logic [CS_W-1:0]     sel_eff;
  logic [NUM_CS-1:0]   cs_onehot;

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Received bits enter at the end opposite to where they finally belong.
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? ((w << 1) | DATA_W'(b)) : ((w >> 1) | (DATA_W'(b) << (DATA_W - 1)));
  endfunction

  always_comb begin
    sel_eff   = (int'(cs_sel_i) < NUM_CS) ? cs_sel_i : '0;
    cs_onehot = NUM_CS'(1) << sel_eff;
  end

  assign accept = tx_valid_i && tx_ready_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    gap_d      = gap_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    start      = 1'b0;

    unique case (state_q)
      IDLE: start = accept;
      LEAD: begin
        if (div_q == '0) begin
          state_d = XFER;
          div_d   = DIV_LOAD;
          half_d  = HALF_LOAD;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      XFER: begin
        if (div_q == '0) begin
          div_d  = DIV_LOAD;
          sclk_d = ~sclk_q;
          // half_q counts down from an odd value, so odd half_q ends on a leading edge
          if (half_q[0] ^ CPHA) begin
            rx_sh_d = rx_shift(rx_sh_q, miso_i);
          end else if (half_q != '0) begin
            mosi_d  = head_bit(tx_sh_q);
            tx_sh_d = shift_out(tx_sh_q);
          end
          if (half_q == '0) state_d = TRAIL;
          else              half_d  = half_q - 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      TRAIL: begin
        if (div_q == '0) begin
          state_d    = GAP;
          gap_d      = GAP_LOAD;
          cs_n_d     = '1;
          mosi_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (accept) start   = 1'b1;
          else        state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = LEAD;
      div_d   = DIV_LOAD;
      cs_n_d  = ~cs_onehot;
      sclk_d  = CPOL;
      rx_sh_d = '0;
      if (!CPHA) begin
        mosi_d  = head_bit(tx_data_i);
        tx_sh_d = shift_out(tx_data_i);
      end else begin
        mosi_d  = 1'b0;
        tx_sh_d = tx_data_i;
      end
    end

    // Ready rises in the last GAP cycle so back-to-back requests see exactly CS_GAP deselect cycles.
    tx_ready_d = (state_d == IDLE) || ((state_d == GAP) && (gap_d == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      half_q     <= '0;
      gap_q      <= '0;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      gap_q      <= gap_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign busy_o     = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL);
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign cs_n_o     = cs_n_q;

endmodule
